// File: rtl/waitstate_mem_stage.sv
// Data-memory stage with a fixed number of wait states per access.
// Holds ready low while a load or store is in flight.
module waitstate_mem_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 4,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              both_q;

  logic              req;
  logic              latch;
  logic              commit;
  logic              legal;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req    = MEM_R_EN | MEM_W_EN;
  assign offset = addr_q - ADDR_W'(BASE_ADDR);
  assign word   = offset >> 2;
  assign idx    = word[IDX_W-1:0];
  assign legal  = (addr_q >= ADDR_W'(BASE_ADDR))
               && (word < ADDR_W'(DEPTH))
               && (addr_q[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    latch   = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          latch   = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          commit  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      both_q  <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      if (latch) begin
        addr_q  <= address;
        wdata_q <= wdata;
        we_q    <= MEM_W_EN;
        both_q  <= MEM_R_EN & MEM_W_EN;
        cnt     <= CNT_W'(WAIT_CYCLES - 1);
      end
      if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Both enables at once commits as a store but still flags err.
      if (commit) begin
        err <= ~legal | both_q;
        if (!legal) begin
          rdata <= '0;
        end else if (!we_q) begin
          rdata <= mem[idx];
        end
      end
      if (state == DONE) begin
        err <= 1'b0;
      end
    end
  end

  // Array is not reset; state is forced to IDLE so no write can slip through.
  always_ff @(posedge clk) begin
    if (commit && legal && we_q) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_waitstate_mem_stage.sv
// Bench for waitstate_mem_stage: two instances (4 and 1 wait states)
// checked against a word-array reference model.
module tb_waitstate_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en  [2];
  logic        w_en  [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        er    [2];

  int checks = 0;
  int errors = 0;

  int          wc       [2];
  logic [31:0] mm       [2][64];
  bit          vv       [2][64];
  logic [31:0] rd_m     [2];
  bit          rd_known [2];

  always #5 clk = ~clk;

  waitstate_mem_stage #(.WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
    .address(addr[0]), .wdata(wd[0]),
    .rdata(rdata[0]), .ready(rdy[0]), .err(er[0])
  );

  waitstate_mem_stage #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
    .address(addr[1]), .wdata(wd[1]),
    .rdata(rdata[1]), .ready(rdy[1]), .err(er[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request, issued in IDLE right after a rising edge.
  task automatic access(input int s, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    int  lows;
    bit  legal;
    int  i;
    bit  exp_err;
    r_en[s] = r;
    w_en[s] = w;
    addr[s] = a;
    wd[s]   = d;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy[s]) break;
      lows++;
    end
    legal = (a >= 32'd1024) && ((a - 32'd1024) / 4 < 64) && (a % 4 == 0);
    i = int'((a - 32'd1024) / 4);
    exp_err = !legal || (r && w);
    if (!legal) begin
      rd_m[s] = '0;
      rd_known[s] = 1'b1;
    end else if (w) begin
      mm[s][i] = d;
      vv[s][i] = 1'b1;
    end else begin
      rd_m[s] = mm[s][i];
      rd_known[s] = vv[s][i];
    end
    chk($sformatf("lat%0d@%h", s, a), lows, wc[s] + 1);
    chk($sformatf("rdy%0d@%h", s, a), {31'd0, rdy[s]}, 32'd1);
    chk($sformatf("err%0d@%h", s, a), {31'd0, er[s]}, {31'd0, exp_err});
    if (rd_known[s]) chk($sformatf("rd%0d@%h", s, a), rdata[s], rd_m[s]);
    @(posedge clk);
    #1;
    r_en[s] = 1'b0;
    w_en[s] = 1'b0;
    @(negedge clk);
    chk($sformatf("errclr%0d", s), {31'd0, er[s]}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    wc[0] = 4;
    wc[1] = 1;
    for (int s = 0; s < 2; s++) begin
      r_en[s] = 1'b0;
      w_en[s] = 1'b0;
      addr[s] = '0;
      wd[s]   = '0;
      rd_m[s] = '0;
      rd_known[s] = 1'b1;
      for (int j = 0; j < 64; j++) vv[s][j] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_rdata%0d", s), rdata[s], 32'd0);
      chk($sformatf("rst_err%0d", s), {31'd0, er[s]}, 32'd0);
      chk($sformatf("rst_ready%0d", s), {31'd0, rdy[s]}, 32'd1);
    end
    @(posedge clk);
    #1;

    access(0, 0, 1, 32'd1024, 32'hDEADBEEF);
    access(0, 1, 0, 32'd1024, 32'h0);
    access(0, 0, 1, 32'd1028, 32'h11);
    access(0, 0, 1, 32'd1032, 32'h22);
    access(0, 1, 0, 32'd1028, 32'h0);
    access(0, 1, 0, 32'd1032, 32'h0);

    access(0, 1, 0, 32'd1020, 32'h0);
    access(0, 0, 1, 32'd1024 + 4 * 64, 32'hBAD0BAD0);
    access(0, 1, 0, 32'd1025, 32'h0);
    access(0, 1, 0, 32'd1024, 32'h0);
    access(0, 1, 0, 32'd1024 + 4 * 63, 32'h0);

    access(0, 1, 1, 32'd1040, 32'h5A);
    access(0, 1, 0, 32'd1040, 32'h0);

    access(0, 0, 1, 32'd1044, 32'h44);
    r_en[0] = 1'b0;
    w_en[0] = 1'b1;
    addr[0] = 32'd1044;
    wd[0]   = 32'h77;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    w_en[0] = 1'b0;
    #1;
    chk("rstmid_ready", {31'd0, rdy[0]}, 32'd1);
    chk("rstmid_rdata", rdata[0], 32'd0);
    chk("rstmid_err", {31'd0, er[0]}, 32'd0);
    rd_m[0] = '0;
    rd_m[1] = '0;
    rd_known[0] = 1'b1;
    rd_known[1] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    access(0, 1, 0, 32'd1044, 32'h0);

    for (int j = 0; j < 64; j++) access(0, 0, 1, 32'd1024 + 4 * j, $urandom);
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      a = 32'd1024 + 4 * $urandom_range(0, 63);
      if (sel == 0) a = 32'd1024 + 4 * $urandom_range(64, 80);
      if (sel == 1) a = a | 32'($urandom_range(1, 3));
      if (sel == 2) a = 32'($urandom_range(0, 1023));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) access(0, 0, 1, a, d);
      else access(0, 1, 0, a, d);
    end

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_ready1", {31'd0, rdy[1]}, 32'd1);
    end
    @(posedge clk);
    #1;
    access(1, 1, 0, 32'd1024, 32'h0);
    access(1, 0, 1, 32'd1100, 32'hA5A5_0001);
    access(1, 1, 0, 32'd1100, 32'h0);
    access(1, 1, 0, 32'd1018, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
